// File: rtl/clkgen_divider.sv
// clkgen_divider: multi-channel divided clock generator running off refclk.
// Every channel counts 0..d-1. Its registered outclk is high for ceil(d/2) cycles per period.
// outclk_stb marks the first high cycle of each period.
// A legal config write realigns all channels through ALIGN, then waits LOCK_CYCLES cycles before locked.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ALIGN    | one cycle: outputs held low, counters seeded from phase
// LOCKWAIT | channels running, waiting LOCK_CYCLES cycles to settle
// LOCKED   | channels running, locked=1, config port open
module clkgen_divider #(
    parameter int NUM_CLK     = 4,
    parameter int DIV_W       = 8,
    parameter int DEF_DIV     = 2,
    parameter int LOCK_CYCLES = 16,
    localparam int CH_W       = (NUM_CLK > 1) ? $clog2(NUM_CLK) : 1
) (
    input  logic               refclk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [DIV_W-1:0]   cfg_div,
    input  logic [DIV_W-1:0]   cfg_phase,
    output logic               cfg_err,
    output logic [NUM_CLK-1:0] outclk,
    output logic [NUM_CLK-1:0] outclk_stb,
    output logic               locked
);

    localparam int LCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_ALIGN    = 2'd0,
        ST_LOCKWAIT = 2'd1,
        ST_LOCKED   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [LCK_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic               cfg_err_q, cfg_err_d;
    logic [DIV_W-1:0]   div_q   [NUM_CLK];
    logic [DIV_W-1:0]   div_d   [NUM_CLK];
    logic [DIV_W-1:0]   phase_q [NUM_CLK];
    logic [DIV_W-1:0]   phase_d [NUM_CLK];
    logic [DIV_W-1:0]   cnt_q   [NUM_CLK];
    logic [DIV_W-1:0]   cnt_d   [NUM_CLK];
    logic [DIV_W-1:0]   load_v  [NUM_CLK];
    logic [DIV_W-1:0]   cnt_eff [NUM_CLK];
    logic [NUM_CLK-1:0] outclk_q, outclk_d;
    logic [NUM_CLK-1:0] stb_q, stb_d;

    logic cfg_legal;
    logic cfg_accept;

    // Request legality: existing channel, divide of at least 2, phase inside one period.
    always_comb begin
        cfg_legal  = (int'(cfg_ch) < NUM_CLK) && (cfg_div >= DIV_W'(2)) && (cfg_phase < cfg_div);
        cfg_accept = (state_q == ST_LOCKED) && cfg_valid && cfg_legal;
    end

    // Next-state logic for the sequencing FSM, the lock timer and the reject pulse.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        cfg_err_d  = 1'b0;
        case (state_q)
            ST_ALIGN: begin
                lock_cnt_d = '0;
                state_d    = ST_LOCKWAIT;
            end
            ST_LOCKWAIT: begin
                lock_cnt_d = lock_cnt_q + LCK_W'(1);
                if (lock_cnt_q == LCK_W'(LOCK_CYCLES - 1)) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (cfg_valid) begin
                    if (cfg_legal) begin
                        state_d = ST_ALIGN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_ALIGN;
            end
        endcase
    end

    // Config storage: only the addressed channel takes the new divide/phase on accept.
    always_comb begin
        for (int i = 0; i < NUM_CLK; i++) begin
            div_d[i]   = div_q[i];
            phase_d[i] = phase_q[i];
            if (cfg_accept && (int'(cfg_ch) == i)) begin
                div_d[i]   = cfg_div;
                phase_d[i] = cfg_phase;
            end
        end
    end

    // Channel counters: in ALIGN the seed value stands in for the counter.
    // Because of that, the first LOCKWAIT cycle already shows the seeded position.
    // Outputs are forced low whenever the next cycle is ALIGN.
    always_comb begin
        for (int i = 0; i < NUM_CLK; i++) begin
            load_v[i]  = (phase_q[i] == '0) ? '0 : div_q[i] - phase_q[i];
            cnt_eff[i] = (state_q == ST_ALIGN) ? load_v[i] : cnt_q[i];
            cnt_d[i]   = (cnt_eff[i] == div_q[i] - DIV_W'(1)) ? '0 : cnt_eff[i] + DIV_W'(1);
            outclk_d[i] = (state_d != ST_ALIGN) && (cnt_eff[i] < div_q[i] - (div_q[i] >> 1));
            stb_d[i]    = (state_d != ST_ALIGN) && (cnt_eff[i] == '0);
        end
    end

    // State, timer and registered outputs.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ALIGN;
            lock_cnt_q <= '0;
            cfg_err_q  <= 1'b0;
            outclk_q   <= '0;
            stb_q      <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            cfg_err_q  <= cfg_err_d;
            outclk_q   <= outclk_d;
            stb_q      <= stb_d;
        end
    end

    // Per-channel config and counter registers.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CLK; i++) begin
                div_q[i]   <= DIV_W'(DEF_DIV);
                phase_q[i] <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CLK; i++) begin
                div_q[i]   <= div_d[i];
                phase_q[i] <= phase_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign outclk     = outclk_q;
    assign outclk_stb = stb_q;
    assign cfg_err    = cfg_err_q;
    assign locked     = (state_q == ST_LOCKED);
    assign cfg_ready  = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_clkgen_divider.sv
// Testbench for clkgen_divider: directed steps plus randomized reconfiguration.
// Outputs are compared every cycle against an arithmetic model of each channel's phase position.
module tb_clkgen_divider;

    localparam int NUM_CLK = 4;
    localparam int DIV_W   = 8;
    localparam int DEF_DIV = 2;
    localparam int LC      = 16;

    logic         refclk;
    logic         rst_n;
    logic         cfg_valid;
    logic         cfg_valid3;
    logic [1:0]   cfg_ch;
    logic [7:0]   cfg_div;
    logic [7:0]   cfg_phase;
    logic         cfg_ready;
    logic         cfg_err;
    logic [3:0]   outclk;
    logic [3:0]   outclk_stb;
    logic         locked;
    logic         cfg_ready3;
    logic         cfg_err3;
    logic [2:0]   outclk3;
    logic [2:0]   outclk_stb3;
    logic         locked3;

    clkgen_divider #(.NUM_CLK(NUM_CLK), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV), .LOCK_CYCLES(LC)) dut (
        .refclk(refclk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_err(cfg_err),
        .outclk(outclk), .outclk_stb(outclk_stb), .locked(locked)
    );

    // Three-channel instance: lets a channel index beyond NUM_CLK be expressed in 2 bits.
    clkgen_divider #(.NUM_CLK(3), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV), .LOCK_CYCLES(LC)) dut3 (
        .refclk(refclk), .rst_n(rst_n), .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_err(cfg_err3),
        .outclk(outclk3), .outclk_stb(outclk_stb3), .locked(locked3)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    int passed = 0;
    int total  = 0;

    // Reference model: since = cycles elapsed since the ALIGN cycle (0 = ALIGN or in reset).
    int m_d [NUM_CLK];
    int m_p [NUM_CLK];
    int since;
    bit exp_err;
    bit m_hs;

    function automatic int pos_of(int ch);
        int d;
        d = m_d[ch];
        return (((since - 1 - m_p[ch]) % d) + d) % d;
    endfunction

    function automatic logic [3:0] exp_clk();
        logic [3:0] v;
        v = '0;
        for (int c = 0; c < NUM_CLK; c++)
            if (since > 0) v[c] = (pos_of(c) < (m_d[c] + 1) / 2);
        return v;
    endfunction

    function automatic logic [3:0] exp_stb();
        logic [3:0] v;
        v = '0;
        for (int c = 0; c < NUM_CLK; c++)
            if (since > 0) v[c] = (pos_of(c) == 0);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    task automatic check_all();
        chk("outclk", 32'(outclk), 32'(exp_clk()));
        chk("outclk_stb", 32'(outclk_stb), 32'(exp_stb()));
        chk("locked", 32'(locked), 32'(since >= LC + 1));
        chk("cfg_ready", 32'(cfg_ready), 32'(since >= LC + 1));
        chk("cfg_err", 32'(cfg_err), 32'(exp_err));
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CLK; c++) begin
            m_d[c] = DEF_DIV;
            m_p[c] = 0;
        end
        since   = 0;
        exp_err = 1'b0;
    endtask

    // One refclk cycle: update the model from the inputs seen at the edge, then check.
    task automatic tick();
        @(posedge refclk);
        m_hs = 1'b0;
        if (rst_n) begin
            exp_err = 1'b0;
            if (since >= LC + 1 && cfg_valid) begin
                m_hs = 1'b1;
                if (int'(cfg_div) >= 2 && cfg_phase < cfg_div) begin
                    m_d[cfg_ch] = int'(cfg_div);
                    m_p[cfg_ch] = int'(cfg_phase);
                    since = 0;
                end else begin
                    exp_err = 1'b1;
                    since++;
                end
            end else begin
                since++;
            end
        end
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Hold a request until the model sees the handshake (bounded).
    task automatic request(input int ch, input int d, input int p);
        int budget;
        cfg_ch    = 2'(ch);
        cfg_div   = 8'(d);
        cfg_phase = 8'(p);
        cfg_valid = 1'b1;
        budget    = 100;
        do begin
            tick();
            budget--;
        end while (!m_hs && budget > 0);
        cfg_valid = 1'b0;
        chk("handshake_timeout", 32'(m_hs), 32'd1);
    endtask

    task automatic wait_lock();
        int budget;
        budget = 100;
        while (since < LC + 1 && budget > 0) begin
            tick();
            budget--;
        end
        chk("lock_timeout", 32'(locked), 32'd1);
    endtask

    task automatic async_reset();
        @(posedge refclk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst3_locked", 32'(locked3), 32'd0);
        ticks(2);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int d;
        int p;
        cfg_valid  = 1'b0;
        cfg_valid3 = 1'b0;
        cfg_ch     = '0;
        cfg_div    = '0;
        cfg_phase  = '0;
        model_reset();
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check_all();
        ticks(2);
        #2;
        rst_n = 1'b1;

        // Defaults: ALIGN, 16 LOCKWAIT cycles, locked on the 17th.
        ticks(16);
        chk("lock_not_yet", 32'(locked), 32'd0);
        tick();
        chk("lock_at_17", 32'(locked), 32'd1);
        chk("dflt_pattern", 32'(outclk ^ outclk_stb), 32'd0);
        ticks(4);

        // Reprogram ch1 d=4 p=0, then ch2 d=5 p=3.
        request(1, 4, 0);
        chk("align_clk", 32'(outclk), 32'd0);
        chk("align_locked", 32'(locked), 32'd0);
        tick();
        chk("ch1_first", 32'({outclk[1], outclk_stb[1]}), 32'b11);
        ticks(20);
        wait_lock();
        request(2, 5, 3);
        ticks(3);
        chk("ch2_before_stb", 32'(outclk_stb[2]), 32'd0);
        tick();
        chk("ch2_first_stb", 32'(outclk_stb[2]), 32'd1);
        ticks(20);
        wait_lock();

        // Illegal requests: rejected with a single err pulse, lock kept.
        request(0, 1, 0);
        chk("ill_div_err", 32'(cfg_err), 32'd1);
        tick();
        chk("ill_div_err_gone", 32'(cfg_err), 32'd0);
        request(3, 6, 6);
        chk("ill_phase_locked", 32'(locked), 32'd1);
        ticks(2);
        cfg_ch     = 2'd3;
        cfg_div    = 8'd4;
        cfg_phase  = 8'd0;
        cfg_valid3 = 1'b1;
        tick();
        cfg_valid3 = 1'b0;
        chk("ill_ch_err", 32'(cfg_err3), 32'd1);
        chk("ill_ch_locked", 32'(locked3), 32'd1);
        tick();
        chk("ill_ch_err_gone", 32'(cfg_err3), 32'd0);
        chk("ill_ch_still_locked", 32'(locked3), 32'd1);

        // Request held through LOCKWAIT, accepted on the first LOCKED cycle.
        request(3, 7, 6);
        request(0, 3, 1);
        ticks(10);

        // Maximum divide: counter must wrap without overflow.
        wait_lock();
        request(3, 255, 254);
        ticks(300);

        // Asynchronous reset mid-run, then relock on defaults.
        wait_lock();
        async_reset();
        ticks(17);
        chk("relock", 32'(locked), 32'd1);

        // Randomized reconfiguration.
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 5))
                0:       d = 255;
                1:       d = $urandom_range(250, 254);
                default: d = $urandom_range(0, 10);
            endcase
            p = $urandom_range(0, (d + 1 > 255) ? 255 : d + 1);
            if ($urandom_range(0, 3) != 0) wait_lock();
            request($urandom_range(0, 3), d, p);
            ticks($urandom_range(0, 30));
            if ($urandom_range(0, 15) == 0) begin
                async_reset();
                ticks(3);
            end
        end
        ticks(5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
